booth_controller: RTL and testbench

Sequencing FSM for the 5-bit radix-2 Booth multiplier datapath. It loads the multiplicand and the multiplier from the shared 5-bit `data_in` bus, then runs N add/subtract-and-shift iterations from the Booth pair `{q1,q0}`. It then presents the 10-bit product on the datapath's 5-bit `data_out` as two consecutive halves, high half first. It sits beside the datapath at the multiplier top level and drives every datapath control line.

---
 rtl/booth_controller.sv | 126 ++++++++++++
 tb/tb_booth_controller.sv | 231 +++++++++++++++++++++++
 2 files changed

// File: rtl/booth_controller.sv
// Sequencing FSM for a radix-2 Booth multiplier: loads both operands from a shared bus,
// runs N evaluate/shift iterations, then presents the product as a high and a low half.
module booth_controller #(
  parameter int unsigned N  = 5,
  parameter int unsigned CW = 3
) (
  input  logic clk,
  input  logic rst_n,
  input  logic start,
  input  logic q1,
  input  logic q0,
  output logic ldM1,
  output logic ldM2,
  output logic clrq,
  output logic ldq,
  output logic sh,
  output logic add,
  output logic sub,
  output logic sel,
  output logic busy,
  output logic out_valid,
  output logic done
);

  typedef enum logic [2:0] {
    StIdle  = 3'd0,
    StLoadX = 3'd1,
    StLoadY = 3'd2,
    StEval  = 3'd3,
    StShift = 3'd4,
    StOutHi = 3'd5,
    StOutLo = 3'd6
  } state_e;

  localparam logic [CW-1:0] LastIter = CW'(N - 1);

  state_e        state_q, state_d;
  logic [CW-1:0] cnt_q, cnt_d;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= StIdle;
      cnt_q   <= '0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
    end
  end

  // Outputs decode from state only, except add/sub/ldq in EVAL which follow the
  // registered Booth pair from the datapath.
  always_comb begin
    state_d   = state_q;
    cnt_d     = cnt_q;
    ldM1      = 1'b0;
    ldM2      = 1'b0;
    clrq      = 1'b0;
    ldq       = 1'b0;
    sh        = 1'b0;
    add       = 1'b0;
    sub       = 1'b0;
    sel       = 1'b0;
    busy      = 1'b1;
    out_valid = 1'b0;
    done      = 1'b0;

    case (state_q)
      StIdle: begin
        busy = 1'b0;
        if (start) begin
          state_d = StLoadX;
        end
      end
      StLoadX: begin
        ldM1    = 1'b1;
        state_d = StLoadY;
      end
      StLoadY: begin
        ldM2    = 1'b1;
        clrq    = 1'b1;
        cnt_d   = '0;
        state_d = StEval;
      end
      StEval: begin
        case ({q1, q0})
          2'b01: begin
            add = 1'b1;
            ldq = 1'b1;
          end
          2'b10: begin
            sub = 1'b1;
            ldq = 1'b1;
          end
          default: ;
        endcase
        state_d = StShift;
      end
      StShift: begin
        sh    = 1'b1;
        cnt_d = cnt_q + CW'(1);
        if (cnt_q == LastIter) begin
          state_d = StOutHi;
        end else begin
          state_d = StEval;
        end
      end
      StOutHi: begin
        out_valid = 1'b1;
        state_d   = StOutLo;
      end
      StOutLo: begin
        sel       = 1'b1;
        out_valid = 1'b1;
        done      = 1'b1;
        state_d   = StIdle;
      end
      default: begin
        // Illegal encoding: recover to IDLE on the next clock.
        busy    = 1'b0;
        cnt_d   = '0;
        state_d = StIdle;
      end
    endcase
  end

endmodule

// File: tb/tb_booth_controller.sv
// Bench for booth_controller: a behavioural Booth datapath closes the loop, a scoreboard
// checks the product halves, and per-cycle checks cover every control line.
module tb_booth_controller;

  logic       clk = 1'b0;
  logic       rst_n;
  logic       start;
  logic       q1, q0;
  logic       ldM1, ldM2, clrq, ldq, sh, add, sub, sel, busy, out_valid, done;
  logic [4:0] op_x, op_y;
  logic [4:0] data_in, data_out;

  int          tests = 0;
  int          fails = 0;
  int unsigned cyc   = 0;

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  booth_controller #(.N(5), .CW(3)) dut (
    .clk      (clk),
    .rst_n    (rst_n),
    .start    (start),
    .q1       (q1),
    .q0       (q0),
    .ldM1     (ldM1),
    .ldM2     (ldM2),
    .clrq     (clrq),
    .ldq      (ldq),
    .sh       (sh),
    .add      (add),
    .sub      (sub),
    .sel      (sel),
    .busy     (busy),
    .out_valid(out_valid),
    .done     (done)
  );

  // Datapath model; the accumulator carries one guard bit so -16 x -16 cannot overflow.
  logic [4:0] m_q, qr_q;
  logic [5:0] a_q;
  logic       qm1_q;

  assign data_in  = ldM1 ? op_x : op_y;
  assign data_out = sel ? qr_q : a_q[4:0];
  assign q1       = qr_q[0];
  assign q0       = qm1_q;

  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      m_q   <= '0;
      qr_q  <= '0;
      a_q   <= '0;
      qm1_q <= 1'b0;
    end else begin
      if (ldM1) m_q <= data_in;
      if (ldM2) qr_q <= data_in;
      if (clrq) begin
        a_q   <= '0;
        qm1_q <= 1'b0;
      end
      if (ldq) a_q <= add ? a_q + {m_q[4], m_q} : a_q - {m_q[4], m_q};
      if (sh) begin
        a_q   <= {a_q[5], a_q[5:1]};
        qr_q  <= {a_q[0], qr_q[4:1]};
        qm1_q <= qr_q[0];
      end
    end
  end

  typedef struct {
    logic [4:0]  hi;
    logic [4:0]  lo;
    int unsigned done_cyc;
  } exp_t;

  exp_t sb_q[$];
  bit   phase = 1'b0;

  // Scoreboard monitor: high half first, then low half together with done.
  always @(negedge clk) begin
    if (rst_n && out_valid) begin
      if (sb_q.size() == 0) begin
        tests++;
        fails++;
        $display("FAIL sb_unexpected: data_out=%b while nothing expected", data_out);
      end else if (!phase) begin
        tests++;
        if (data_out !== sb_q[0].hi || done !== 1'b0) begin
          fails++;
          $display("FAIL sb_hi: data_out=%b done=%b, required %b done=0",
                   data_out, done, sb_q[0].hi);
        end
        phase = 1'b1;
      end else begin
        exp_t e;
        e = sb_q.pop_front();
        tests++;
        if (data_out !== e.lo || done !== 1'b1 || cyc != e.done_cyc) begin
          fails++;
          $display("FAIL sb_lo: data_out=%b done=%b cycle=%0d, required %b done=1 cycle=%0d",
                   data_out, done, cyc, e.lo, e.done_cyc);
        end
        phase = 1'b0;
      end
    end
  end

  function automatic logic [10:0] ctl_vec();
    return {busy, ldM1, ldM2, clrq, ldq, sh, add, sub, sel, out_valid, done};
  endfunction

  // Expected control vector for cycle k of an operation (k=0 is the IDLE start sample).
  task automatic check_ctl(input int k);
    logic [10:0] exp_v;
    logic        ev;
    ev    = (k >= 3) && (k <= 11) && (k % 2 == 1);
    exp_v = {(k >= 1 && k <= 14), (k == 1), (k == 2), (k == 2),
             ev & (q1 ^ q0), (k >= 4 && k <= 12 && k % 2 == 0),
             ev & ~q1 & q0, ev & q1 & ~q0,
             (k == 14), (k == 13 || k == 14), (k == 14)};
    tests++;
    if (ctl_vec() !== exp_v) begin
      fails++;
      $display("FAIL ctl@%0d: {busy,ldM1,ldM2,clrq,ldq,sh,add,sub,sel,ov,done}=%b, required %b",
               k, ctl_vec(), exp_v);
    end
  endtask

  task automatic run_op(input logic [4:0] x, input logic [4:0] y, input logic [4:0] hi,
                        input logic [4:0] lo, input bit hold, input bit poke,
                        input bit chained);
    int unsigned c0;
    int          k0;
    exp_t        e;
    if (!chained) begin
      @(posedge clk);
      #1;
      c0    = cyc;
      k0    = 0;
      start = 1'b1;
    end else begin
      c0    = cyc - 1;
      k0    = 1;
      start = 1'b0;
    end
    op_x       = x;
    op_y       = y;
    e.hi       = hi;
    e.lo       = lo;
    e.done_cyc = c0 + 14;
    sb_q.push_back(e);
    for (int k = k0; k <= 15; k++) begin
      @(negedge clk);
      check_ctl(k);
      @(posedge clk);
      #1;
      if (!hold) start = 1'b0;
      if (poke) start = (k == 4);
    end
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    rst_n = 1'b0;
    start = 1'b0;
    op_x  = '0;
    op_y  = '0;
    #12;
    tests++;
    if (ctl_vec() !== 11'd0) begin
      fails++;
      $display("FAIL reset: outputs=%b, required all zero", ctl_vec());
    end
    @(negedge clk);
    rst_n = 1'b1;

    run_op(5'b00111, 5'b00101, 5'b00001, 5'b00011, 1'b0, 1'b0, 1'b0);  //  7 x  5 =   35
    run_op(5'b00011, 5'b11110, 5'b11111, 5'b11010, 1'b0, 1'b0, 1'b0);  //  3 x -2 =   -6
    run_op(5'b10000, 5'b10000, 5'b01000, 5'b00000, 1'b0, 1'b0, 1'b0);  // -16 x -16 = 256
    // start held high: second operation's LOAD_X lands two cycles after OUT_LO
    run_op(5'b01111, 5'b10000, 5'b11000, 5'b10000, 1'b1, 1'b0, 1'b0);  // 15 x -16 = -240
    run_op(5'b00011, 5'b11110, 5'b11111, 5'b11010, 1'b0, 1'b0, 1'b1);

    // Abort during the third SHIFT (cycle 8)
    @(posedge clk);
    #1;
    op_x  = 5'b00111;
    op_y  = 5'b00101;
    start = 1'b1;
    @(posedge clk);
    #1;
    start = 1'b0;
    repeat (7) @(posedge clk);
    #1;
    tests++;
    if (sh !== 1'b1 || busy !== 1'b1) begin
      fails++;
      $display("FAIL abort_pre: sh=%b busy=%b, required 1 1", sh, busy);
    end
    #2;
    rst_n = 1'b0;
    #1;
    tests++;
    if (ctl_vec() !== 11'd0) begin
      fails++;
      $display("FAIL abort_reset: outputs=%b, required all zero", ctl_vec());
    end
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    run_op(5'b00111, 5'b00101, 5'b00001, 5'b00011, 1'b0, 1'b0, 1'b0);

    // start pulsed during EVAL must be ignored
    run_op(5'b00011, 5'b11110, 5'b11111, 5'b11010, 1'b0, 1'b1, 1'b0);

    repeat (3) @(negedge clk);
    tests++;
    if (sb_q.size() != 0 || busy !== 1'b0) begin
      fails++;
      $display("FAIL drain: pending=%0d busy=%b, required 0 0", sb_q.size(), busy);
    end
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
